// File: rtl/key_expansion_128_if.sv
// Handshake bundle between a key consumer/controller and key_expansion_128.
// master drives start/key/accept; slave (the expander) returns keys and status.
interface key_expansion_128_if;
    logic         start;
    logic [127:0] cipherKey;
    logic         ready;
    logic [127:0] roundKey;
    logic [3:0]   roundIndex;
    logic         roundKeyValid;
    logic         roundKeyAccept;
    logic         done;

    modport master (
        output start, cipherKey, roundKeyAccept,
        input  ready, roundKey, roundIndex, roundKeyValid, done
    );

    modport slave (
        input  start, cipherKey, roundKeyAccept,
        output ready, roundKey, roundIndex, roundKeyValid, done
    );
endinterface

// File: rtl/key_expansion_128.sv
// AES-128 round-key generator, one shared S-box; key 0 one cycle after start, 6 cycles per later key.
// Each key is held on roundKey until roundKeyValid & roundKeyAccept; no further work happens while stalled.
module key_expansion_128 #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clock50MHz,
    input  logic               reset,
    key_expansion_128_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Entry i sits at bits [(255-i)*8 +: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_SUB,
        S_XOR
    } state_t;

    state_t       state, state_n;
    logic         ready_q, ready_n;
    logic         valid_q, valid_n;
    logic         done_q, done_n;
    logic [127:0] key_q;
    logic [31:0]  temp;
    logic [7:0]   rcon;
    logic [1:0]   cnt;
    logic [3:0]   idx;

    logic         launch;
    logic         xfer;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [31:0]  t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    // ready_q stays low during the done cycle, so a start there is dropped
    assign launch = (state == S_IDLE) && ready_q && bus.start;
    assign xfer   = (state == S_PRESENT) && valid_q && bus.roundKeyAccept;

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= ready_n;
            valid_q <= valid_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        ready_n = ready_q;
        valid_n = valid_q;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                if (launch) begin
                    ready_n = 1'b0;
                    valid_n = 1'b1;
                    state_n = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    if (idx == LAST_ROUND) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_SUB;
                    end
                end
            end
            S_SUB: begin
                if (cnt == 2'd3) state_n = S_XOR;
            end
            S_XOR: begin
                valid_n = 1'b1;
                state_n = S_PRESENT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // RotWord folded into the byte select: temp byte c takes w3 byte (c+1) mod 4
    always_comb begin
        sbox_in = key_q[23:16];
        case (cnt)
            2'd0: sbox_in = key_q[23:16];
            2'd1: sbox_in = key_q[15:8];
            2'd2: sbox_in = key_q[7:0];
            2'd3: sbox_in = key_q[31:24];
            default: sbox_in = key_q[23:16];
        endcase
    end

    assign sbox_out = SBOX[{~sbox_in, 3'b000} +: 8];

    assign t_word = temp ^ {rcon, 24'h000000};
    assign w0_n   = key_q[127:96] ^ t_word;
    assign w1_n   = key_q[95:64]  ^ w0_n;
    assign w2_n   = key_q[63:32]  ^ w1_n;
    assign w3_n   = key_q[31:0]   ^ w2_n;

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            key_q <= '0;
            temp  <= '0;
            rcon  <= 8'h01;
            cnt   <= 2'd0;
            idx   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        key_q <= bus.cipherKey;
                        idx   <= 4'd0;
                        rcon  <= 8'h01;
                    end
                end
                S_PRESENT: begin
                    if (xfer) cnt <= 2'd0;
                end
                S_SUB: begin
                    case (cnt)
                        2'd0: temp[31:24] <= sbox_out;
                        2'd1: temp[23:16] <= sbox_out;
                        2'd2: temp[15:8]  <= sbox_out;
                        2'd3: temp[7:0]   <= sbox_out;
                        default: temp[31:24] <= sbox_out;
                    endcase
                    cnt <= cnt + 2'd1;
                end
                S_XOR: begin
                    key_q <= {w0_n, w1_n, w2_n, w3_n};
                    idx   <= idx + 4'd1;
                    rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
                default: ;
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.roundKey      = key_q;
    assign bus.roundIndex    = idx;
    assign bus.roundKeyValid = valid_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_key_expansion_128.sv
// Directed bench for key_expansion_128: FIPS-197 vectors, backpressure, busy start, reset, short schedule.
module tb_key_expansion_128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_expansion_128_if bus ();
    key_expansion_128_if bus2 ();

    key_expansion_128 #(.NUM_ROUNDS(10)) u_dut (
        .clock50MHz(clk),
        .reset     (rst),
        .bus       (bus)
    );

    key_expansion_128 #(.NUM_ROUNDS(2)) u_dut2 (
        .clock50MHz(clk),
        .reset     (rst),
        .bus       (bus2)
    );

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] v1_keys [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int errors = 0;
    int checks = 0;

    logic [127:0] got_key [11];
    int n_xfer, done_cyc, n_done, ready_early, hold_bad;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one expansion on the NUM_ROUNDS=10 instance, capturing each transferred key.
    task automatic run_exp(input logic [127:0] key, input int hold_idx, input int hold_n,
                           input int busy_idx, input logic [127:0] busy_key);
        int cyc;
        int held;
        bit busy_sent;
        bit fin;
        logic [127:0] hold_key;
        logic [3:0]   hold_ri;
        n_xfer = 0; done_cyc = -1; n_done = 0; ready_early = 0; hold_bad = 0;
        held = 0; busy_sent = 0; fin = 0; cyc = 0;
        hold_key = '0; hold_ri = '0;
        for (int i = 0; i < 11; i++) got_key[i] = 'x;
        bus.cipherKey      = key;
        bus.start          = 1'b1;
        bus.roundKeyAccept = 1'b1;
        while (!fin && cyc < 400) begin
            tick();
            cyc++;
            bus.start     = 1'b0;
            bus.cipherKey = ~key;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                fin = 1;
            end else if (bus.ready) begin
                ready_early++;
            end
            if (!fin && bus.roundKeyValid) begin
                if (int'(bus.roundIndex) == hold_idx && held < hold_n) begin
                    if (held == 0) begin
                        hold_key = bus.roundKey;
                        hold_ri  = bus.roundIndex;
                    end else if (bus.roundKey !== hold_key || bus.roundIndex !== hold_ri) begin
                        hold_bad++;
                    end
                    held++;
                    bus.roundKeyAccept = 1'b0;
                end else begin
                    bus.roundKeyAccept = 1'b1;
                    if (bus.roundIndex <= 4'd10) got_key[bus.roundIndex] = bus.roundKey;
                    n_xfer++;
                end
                if (int'(bus.roundIndex) == busy_idx && !busy_sent) begin
                    bus.start     = 1'b1;
                    bus.cipherKey = busy_key;
                    busy_sent     = 1;
                end
            end
        end
    endtask

    initial begin
        int cyc;
        int seen_done;
        int n2;
        int done2;
        logic [3:0]   idx_seq [3];
        logic [127:0] key2_got;

        bus.start = 1'b0;  bus.cipherKey = '0;  bus.roundKeyAccept = 1'b0;
        bus2.start = 1'b0; bus2.cipherKey = '0; bus2.roundKeyAccept = 1'b1;
        key2_got = '0;
        for (int i = 0; i < 3; i++) idx_seq[i] = 4'hf;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(bus.ready), 128'd1);
        chk("rst_key",   bus.roundKey, 128'd0);
        chk("rst_index", 128'(bus.roundIndex), 128'd0);
        chk("rst_valid", 128'(bus.roundKeyValid), 128'd0);
        chk("rst_done",  128'(bus.done), 128'd0);
        rst = 1'b0;
        tick();

        // Zero-wait expansion
        run_exp(KEY1, -1, 0, -1, '0);
        chk("v1_xfers",    128'(n_xfer), 128'd11);
        chk("v1_done_cnt", 128'(n_done), 128'd1);
        chk("v1_done_cyc", 128'(done_cyc), 128'd62);
        chk("v1_ready_busy", 128'(ready_early), 128'd0);
        for (int i = 0; i < 11; i++) chk($sformatf("v1_key%0d", i), got_key[i], v1_keys[i]);

        // start in the done cycle is dropped; ready rises a cycle later
        bus.start = 1'b1;
        bus.cipherKey = KEY2;
        tick();
        bus.start = 1'b0;
        chk("done_start_valid", 128'(bus.roundKeyValid), 128'd0);
        chk("done_start_ready", 128'(bus.ready), 128'd1);
        chk("done_single",      128'(bus.done), 128'd0);

        // Second vector
        run_exp(KEY2, -1, 0, -1, '0);
        chk("v2_key1",  got_key[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk("v2_key10", got_key[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("v2_ark",   got_key[0] ^ 128'h00112233445566778899aabbccddeeff,
                        128'h00102030405060708090a0b0c0d0e0f0);
        chk("v2_done_cyc", 128'(done_cyc), 128'd62);
        tick();

        // Backpressure at index 3 for 20 cycles
        run_exp(KEY1, 3, 20, -1, '0);
        chk("bp_stable",   128'(hold_bad), 128'd0);
        chk("bp_xfers",    128'(n_xfer), 128'd11);
        chk("bp_done_cyc", 128'(done_cyc), 128'd82);
        for (int i = 0; i < 11; i++) chk($sformatf("bp_key%0d", i), got_key[i], v1_keys[i]);
        tick();

        // Start with another key while busy at index 5
        run_exp(KEY1, -1, 0, 5, KEY2);
        chk("busy_ready", 128'(ready_early), 128'd0);
        chk("busy_done_cnt", 128'(n_done), 128'd1);
        chk("busy_done_cyc", 128'(done_cyc), 128'd62);
        for (int i = 6; i < 11; i++) chk($sformatf("busy_key%0d", i), got_key[i], v1_keys[i]);
        tick();

        // Reset while computing round 7
        bus.cipherKey = KEY1;
        bus.start = 1'b1;
        bus.roundKeyAccept = 1'b1;
        cyc = 0;
        tick();
        bus.start = 1'b0;
        while (!(bus.roundKeyValid && bus.roundIndex == 4'd6) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rst_mid_reach", 128'(cyc < 200), 128'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ready", 128'(bus.ready), 128'd1);
        chk("rst_mid_valid", 128'(bus.roundKeyValid), 128'd0);
        chk("rst_mid_index", 128'(bus.roundIndex), 128'd0);
        chk("rst_mid_key",   bus.roundKey, 128'd0);
        seen_done = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        chk("rst_mid_no_done", 128'(seen_done), 128'd0);

        run_exp(KEY1, -1, 0, -1, '0);
        chk("rst_rerun_done_cyc", 128'(done_cyc), 128'd62);
        for (int i = 0; i < 11; i++) chk($sformatf("rerun_key%0d", i), got_key[i], v1_keys[i]);
        tick();

        // NUM_ROUNDS=2 instance
        bus2.cipherKey = KEY1;
        bus2.start = 1'b1;
        n2 = 0;
        done2 = -1;
        cyc = 0;
        while (done2 < 0 && cyc < 100) begin
            tick();
            cyc++;
            bus2.start = 1'b0;
            if (bus2.done) begin
                done2 = cyc;
            end else if (bus2.roundKeyValid) begin
                if (n2 < 3) idx_seq[n2] = bus2.roundIndex;
                if (bus2.roundIndex == 4'd2) key2_got = bus2.roundKey;
                n2++;
            end
        end
        chk("nr2_xfers",    128'(n2), 128'd3);
        chk("nr2_idx0",     128'(idx_seq[0]), 128'd0);
        chk("nr2_idx1",     128'(idx_seq[1]), 128'd1);
        chk("nr2_idx2",     128'(idx_seq[2]), 128'd2);
        chk("nr2_done_cyc", 128'(done2), 128'd14);
        chk("nr2_key2",     key2_got, v1_keys[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_expansion_128.md
Name: key_expansion_128

Overview:
- Generates the eleven AES-128 round keys (rounds 0..10) from a 128-bit cipher key, one key per handshake.
- Sits directly upstream of add_round_key and drives its roundKey input.
- Uses a single internal S-box: a 256-entry combinational lookup, FIPS-197 table.
- SubWord is therefore serialised over 4 cycles per round; throughput is traded for area.

Parameters:
- NUM_ROUNDS, 10: index of the last round key emitted. Legal range 1..10; only 10 is used for AES-128.

Ports:
- clock50MHz  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request expansion of cipherKey; sampled only when ready=1
- cipherKey  input  128  cipher key; [127:96]=w0, [31:0]=w3; byte 0 is most significant (FIPS-197 order)
- ready  output  1  high in IDLE; block can accept start
- roundKey  output  128  current round key; stable while roundKeyValid=1
- roundIndex  output  4  round number of roundKey, 0..NUM_ROUNDS
- roundKeyValid  output  1  roundKey/roundIndex valid
- roundKeyAccept  input  1  downstream consumes the key; a transfer occurs on a cycle with roundKeyValid & roundKeyAccept
- done  output  1  one-cycle pulse on the cycle after the final key (roundIndex=NUM_ROUNDS) transfers

Behaviour:
- Clock and reset
  - Single clock domain. Reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values: ready=1, roundKey=0, roundIndex=0, roundKeyValid=0, done=0. Internal state=IDLE, rcon=8'h01, byte counter=0.
- State IDLE (ready=1)
  - start=1: latch cipherKey into the key register, roundIndex=0, rcon=8'h01, ready=0 → PRESENT.
  - First roundKeyValid rises on the cycle after start is sampled; latency is 1.
- State PRESENT (roundKeyValid=1)
  - roundKey holds the key register.
  - Without accept: hold all outputs indefinitely.
  - On transfer with roundIndex==NUM_ROUNDS: roundKeyValid=0, done=1 for one cycle, ready=1 → IDLE.
  - On transfer otherwise: roundKeyValid=0, byte counter=0 → SUB.
- State SUB (4 cycles, counter 0..3)
  - Each cycle, S-box one byte of RotWord(w3) into temp byte [counter].
  - RotWord(b0 b1 b2 b3) = b1 b2 b3 b0.
  - counter==3 → XOR.
- State XOR (1 cycle)
  - t = temp ^ {rcon, 24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - Load the key register; roundIndex+1.
  - rcon = xtime(rcon): shift left; XOR 8'h1b if bit 7 was set. Sequence 01,02,04,08,10,20,40,80,1b,36.
  - → PRESENT.
- Timing
  - Accept at cycle t → next roundKeyValid at t+6 (SUB t+1..t+4, XOR t+5).
  - A full expansion with accept held high takes 1 + 10×6 + 1 cycles from start to done.
- Boundary conditions
  - start while ready=0 is ignored; the latched key is unaffected.
  - start on the same cycle as done is ignored; ready rises the following cycle.
  - roundKeyAccept while roundKeyValid=0 is ignored.
  - cipherKey is sampled only at start; later changes do not affect an expansion in progress.
  - reset asserted in any state returns to reset values on the next edge; a partial expansion is discarded and no done pulse is produced.
  - roundIndex never exceeds NUM_ROUNDS; no wrap-around.

Test Plan:
- Zero-wait expansion
  - Stimulus: reset 3 cycles; start with cipherKey=2b7e151628aed2a6abf7158809cf4f3c; accept held 1.
  - Required: index0 = key; index1 = a0fafe1788542cb123a339392a6c7605; index10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: done pulses once, 62 cycles after start.
- Second vector
  - Stimulus: cipherKey=000102030405060708090a0b0c0d0e0f.
  - Required: index1 = d6aa74fdd2af72fadaa678f1d6ab76fe; index10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Required: the index0 key XOR data 00112233445566778899aabbccddeeff through add_round_key gives 00102030405060708090a0b0c0d0e0f0.
- Backpressure
  - Stimulus: accept held low 20 cycles at index 3, then pulsed.
  - Required: roundKey and roundIndex stable throughout; the sequence is identical to the zero-wait run.
- Start while busy
  - Stimulus: start with a different cipherKey at index 5.
  - Required: ignored; remaining keys match the original vector; ready=0 until done.
- Reset mid-operation
  - Stimulus: reset during SUB of round 7.
  - Required: next cycle ready=1, roundKeyValid=0, roundIndex=0, done never pulses; a fresh start reproduces the full vector.
- NUM_ROUNDS=2
  - Required: exactly 3 transfers (indices 0,1,2); done follows index 2.
